// File: rtl/ksk_stage_buffer_pkg.sv
// Shared defaults and types for the key-switching-key stage buffer.
// Defaults describe a 12-bank, 16-stage buffer of 39-bit coefficients.
package ksk_stage_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 39;
    localparam int DEF_NUM_BANKS  = 12;
    localparam int DEF_PACK       = 8;
    localparam int DEF_LINES      = 512;
    localparam int DEF_NUM_STAGES = 16;
    localparam int DEF_RD_LATENCY = 3;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_t;

endpackage

// File: rtl/ksk_stage_buffer_bank_ram.sv
// Simple dual-port line RAM for one key bank with a LATENCY-deep registered read path.
// The read samples the array before a same-cycle write lands, so it returns old data.
module ksk_bank_ram #(
    parameter int WIDTH   = 312,
    parameter int DEPTH   = 8192,
    parameter int LATENCY = 3,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pipe_reg [LATENCY];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            pipe_reg[0] <= mem[rd_addr];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
        end
    end

    assign rd_data = pipe_reg[LATENCY-1];

endmodule

// File: rtl/ksk_stage_buffer.sv
// Multi-stage key buffer: a load FSM fills one stage line by line across all banks,
// while a fully pipelined read port fetches one coefficient per bank per cycle.
module ksk_stage_buffer
    import ksk_stage_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int PACK       = DEF_PACK,
    parameter int LINES      = DEF_LINES,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    localparam int SW  = $clog2(NUM_STAGES),
    localparam int BW  = $clog2(NUM_BANKS),
    localparam int LW  = $clog2(LINES),
    localparam int PW  = $clog2(PACK),
    localparam int RAW = LW + PW
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_load_start,
    input  logic [SW-1:0]                   i_load_stage,
    input  logic                            i_wr_en,
    input  logic [BW-1:0]                   i_wr_bank,
    input  logic [LW-1:0]                   i_wr_addr,
    input  logic [PACK*DATA_WIDTH-1:0]      i_wr_data,
    output logic                            o_load_busy,
    output logic                            o_load_done,
    input  logic                            i_release,
    input  logic [SW-1:0]                   i_release_stage,
    output logic [NUM_STAGES-1:0]           o_stage_loaded,
    input  logic                            i_rd_en,
    input  logic [SW-1:0]                   i_rd_stage,
    input  logic [RAW-1:0]                  i_rd_addr,
    output logic                            o_rd_valid,
    output logic                            o_rd_err,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_rd_data,
    output logic                            o_wr_drop
);

    localparam int             LINE_W = PACK * DATA_WIDTH;
    localparam int             CW     = $clog2(NUM_BANKS * LINES + 1);
    localparam logic [CW-1:0]  TOTAL  = CW'(NUM_BANKS * LINES);
    localparam logic [BW:0]    NB     = (BW+1)'(NUM_BANKS);

    load_state_t           state_reg;
    logic [SW-1:0]         load_stage_reg;
    logic [CW-1:0]         count_reg;
    logic [NUM_STAGES-1:0] loaded_reg;
    logic [NUM_STAGES-1:0] loaded_next;
    logic                  load_done_reg;
    logic                  wr_drop_reg;
    logic                  in_load;
    logic                  wr_accept;
    logic                  last_write;

    assign in_load = (state_reg == LOAD);
    // A write coinciding with a (re)start belongs to neither stage, so it is dropped.
    assign wr_accept  = in_load && !i_load_start && i_wr_en && ({1'b0, i_wr_bank} < NB);
    assign last_write = wr_accept && ((count_reg + CW'(1)) == TOTAL);

    // Completion is applied last so it wins over a same-cycle release of that stage.
    always_comb begin
        loaded_next = loaded_reg;
        if (i_release && !(in_load && (i_release_stage == load_stage_reg))) begin
            loaded_next[i_release_stage] = 1'b0;
        end
        if (i_load_start) begin
            loaded_next[i_load_stage] = 1'b0;
        end
        if (last_write) begin
            loaded_next[load_stage_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            load_stage_reg <= '0;
            count_reg      <= '0;
            loaded_reg     <= '0;
            load_done_reg  <= 1'b0;
            wr_drop_reg    <= 1'b0;
        end else begin
            loaded_reg    <= loaded_next;
            load_done_reg <= last_write;
            wr_drop_reg   <= i_wr_en && !wr_accept;
            case (state_reg)
                IDLE: begin
                    if (i_load_start) begin
                        state_reg      <= LOAD;
                        load_stage_reg <= i_load_stage;
                        count_reg      <= '0;
                    end
                end
                LOAD: begin
                    if (i_load_start) begin
                        load_stage_reg <= i_load_stage;
                        count_reg      <= '0;
                    end else if (last_write) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else if (wr_accept) begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_load_busy    = in_load;
    assign o_load_done    = load_done_reg;
    assign o_wr_drop      = wr_drop_reg;
    assign o_stage_loaded = loaded_reg;

    // Read side: valid, error and lane travel alongside the RAM read pipeline.
    logic [RD_LATENCY-1:0] valid_pipe_reg;
    logic [RD_LATENCY-1:0] err_pipe_reg;
    logic [PW-1:0]         lane_pipe_reg [RD_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe_reg <= '0;
            err_pipe_reg   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                lane_pipe_reg[i] <= '0;
            end
        end else begin
            valid_pipe_reg[0] <= i_rd_en;
            err_pipe_reg[0]   <= i_rd_en && !loaded_reg[i_rd_stage];
            lane_pipe_reg[0]  <= i_rd_addr[PW-1:0];
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                err_pipe_reg[i]   <= err_pipe_reg[i-1];
                lane_pipe_reg[i]  <= lane_pipe_reg[i-1];
            end
        end
    end

    logic          rd_show;
    logic [PW-1:0] lane_q;
    logic [LINE_W-1:0] bank_q [NUM_BANKS];

    assign o_rd_valid = valid_pipe_reg[RD_LATENCY-1];
    assign o_rd_err   = err_pipe_reg[RD_LATENCY-1];
    assign rd_show    = o_rd_valid && !o_rd_err;
    assign lane_q     = lane_pipe_reg[RD_LATENCY-1];

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            ksk_bank_ram #(
                .WIDTH   (LINE_W),
                .DEPTH   (NUM_STAGES * LINES),
                .LATENCY (RD_LATENCY)
            ) u_ram (
                .clk     (clk),
                .wr_en   (wr_accept && (i_wr_bank == BW'(gi))),
                .wr_addr ({load_stage_reg, i_wr_addr}),
                .wr_data (i_wr_data),
                .rd_en   (i_rd_en),
                .rd_addr ({i_rd_stage, i_rd_addr[RAW-1:PW]}),
                .rd_data (bank_q[gi])
            );

            assign o_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                rd_show ? bank_q[gi][lane_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_ksk_stage_buffer.sv
// Scoreboard bench for ksk_stage_buffer: reads push expectations, a negedge monitor
// pops and compares them; control outputs are checked directly by the stimulus.
module tb_ksk_stage_buffer;

    localparam int DW    = 39;
    localparam int NB    = 12;
    localparam int PACK  = 8;
    localparam int LINES = 512;
    localparam int NS    = 16;
    localparam int LAT   = 3;
    localparam int XW    = NB * DW;

    typedef logic [XW-1:0] wide_t;
    typedef struct {
        logic  err;
        wide_t data;
        int    due;
        int    id;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_load_start;
    logic [3:0]           i_load_stage;
    logic                 i_wr_en;
    logic [3:0]           i_wr_bank;
    logic [8:0]           i_wr_addr;
    logic [PACK*DW-1:0]   i_wr_data;
    logic                 o_load_busy;
    logic                 o_load_done;
    logic                 i_release;
    logic [3:0]           i_release_stage;
    logic [NS-1:0]        o_stage_loaded;
    logic                 i_rd_en;
    logic [3:0]           i_rd_stage;
    logic [11:0]          i_rd_addr;
    logic                 o_rd_valid;
    logic                 o_rd_err;
    logic [XW-1:0]        o_rd_data;
    logic                 o_wr_drop;

    ksk_stage_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .i_load_start    (i_load_start),
        .i_load_stage    (i_load_stage),
        .i_wr_en         (i_wr_en),
        .i_wr_bank       (i_wr_bank),
        .i_wr_addr       (i_wr_addr),
        .i_wr_data       (i_wr_data),
        .o_load_busy     (o_load_busy),
        .o_load_done     (o_load_done),
        .i_release       (i_release),
        .i_release_stage (i_release_stage),
        .o_stage_loaded  (o_stage_loaded),
        .i_rd_en         (i_rd_en),
        .i_rd_stage      (i_rd_stage),
        .i_rd_addr       (i_rd_addr),
        .o_rd_valid      (o_rd_valid),
        .o_rd_err        (o_rd_err),
        .o_rd_data       (o_rd_data),
        .o_wr_drop       (o_wr_drop)
    );

    always #5 clk = ~clk;

    int   cycle = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    int   next_id = 0;
    exp_t sb_q[$];

    always @(posedge clk) cycle <= cycle + 1;

    // Coefficient pattern: stage, bank, line and lane fields over a fixed filler.
    function automatic logic [DW-1:0] coef(input int s, input int b, input int l, input int k);
        logic [3:0] sv = s[3:0];
        logic [3:0] bv = b[3:0];
        logic [8:0] lv = l[8:0];
        logic [2:0] kv = k[2:0];
        return {sv, bv, lv, kv, 19'h15A3C};
    endfunction

    function automatic logic [PACK*DW-1:0] line_data(input int s, input int b, input int l);
        logic [PACK*DW-1:0] r;
        for (int k = 0; k < PACK; k++) r[k*DW +: DW] = coef(s, b, l, k);
        return r;
    endfunction

    function automatic wide_t read_word(input int s, input int addr);
        wide_t r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = coef(s, b, addr / PACK, addr % PACK);
        return r;
    endfunction

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int s, input int addr, input logic exp_err);
        exp_t e;
        i_rd_en    = 1'b1;
        i_rd_stage = s[3:0];
        i_rd_addr  = addr[11:0];
        e.err  = exp_err;
        e.data = exp_err ? '0 : read_word(s, addr);
        e.due  = cycle + LAT;
        e.id   = next_id++;
        sb_q.push_back(e);
        tick();
        i_rd_en = 1'b0;
    endtask

    // Starts a load of stage s, injects one out-of-range bank write, then issues n writes.
    task automatic load(input int s, input int n, input logic rel, input int rel_stage);
        i_load_start = 1'b1;
        i_load_stage = s[3:0];
        tick();
        i_load_start = 1'b0;
        check("busy_after_start", wide_t'(o_load_busy), wide_t'(1'b1));
        check("stage_cleared_on_start", wide_t'(o_stage_loaded[s]), wide_t'(1'b0));
        i_wr_en   = 1'b1;
        i_wr_bank = 4'd15;
        tick();
        i_wr_en = 1'b0;
        check("drop_bad_bank", wide_t'(o_wr_drop), wide_t'(1'b1));
        for (int i = 0; i < n; i++) begin
            i_wr_en   = 1'b1;
            i_wr_bank = 4'(i / LINES);
            i_wr_addr = 9'(i % LINES);
            i_wr_data = line_data(s, i / LINES, i % LINES);
            if (rel && i == n - 1) begin
                i_release       = 1'b1;
                i_release_stage = rel_stage[3:0];
            end
            tick();
        end
        i_wr_en   = 1'b0;
        i_release = 1'b0;
        $display("load stage=%0d writes=%0d busy=%0b done=%0b", s, n, o_load_busy, o_load_done);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (o_rd_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL rd_unexpected: got valid read err=%0b with no request outstanding", o_rd_err);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rd_data", o_rd_data, e.data);
                    check("rd_err", wide_t'(o_rd_err), wide_t'(e.err));
                    check("rd_latency", wide_t'(cycle), wide_t'(e.due));
                    $display("read id=%0d err=%0b cycle=%0d", e.id, o_rd_err, cycle);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_load_start = 1'b0; i_load_stage = '0;
        i_wr_en = 1'b0; i_wr_bank = '0; i_wr_addr = '0; i_wr_data = '0;
        i_release = 1'b0; i_release_stage = '0;
        i_rd_en = 1'b0; i_rd_stage = '0; i_rd_addr = '0;
        repeat (3) tick();
        check("rst_bitmap", wide_t'(o_stage_loaded), wide_t'(16'h0000));
        check("rst_busy", wide_t'(o_load_busy), wide_t'(1'b0));
        check("rst_done", wide_t'(o_load_done), wide_t'(1'b0));
        check("rst_drop", wide_t'(o_wr_drop), wide_t'(1'b0));
        check("rst_valid", wide_t'(o_rd_valid), wide_t'(1'b0));
        check("rst_data", o_rd_data, '0);
        rst = 1'b0;
        tick();

        load(3, NB * LINES, 1'b0, 0);
        check("load3_done", wide_t'(o_load_done), wide_t'(1'b1));
        check("load3_idle", wide_t'(o_load_busy), wide_t'(1'b0));
        check("load3_bitmap", wide_t'(o_stage_loaded), wide_t'(16'h0008));
        tick();
        check("load3_done_pulse", wide_t'(o_load_done), wide_t'(1'b0));

        rd(3, 'h00B, 1'b0);
        rd(5, 'h00B, 1'b1);

        // Write while idle: dropped, RAM untouched.
        i_wr_en = 1'b1; i_wr_bank = 4'd0; i_wr_addr = 9'd1; i_wr_data = '1;
        tick();
        i_wr_en = 1'b0;
        check("idle_drop", wide_t'(o_wr_drop), wide_t'(1'b1));
        tick();
        check("idle_drop_pulse", wide_t'(o_wr_drop), wide_t'(1'b0));
        rd(3, 'h00B, 1'b0);

        for (int a = 0; a < 16; a++) rd(3, a, 1'b0);
        rd(3, 'hFFF, 1'b0);

        load(7, NB * LINES, 1'b1, 3);
        check("rel3_load7_bitmap", wide_t'(o_stage_loaded), wide_t'(16'h0080));
        load(9, NB * LINES, 1'b1, 9);
        check("rel_same_stage_bitmap", wide_t'(o_stage_loaded), wide_t'(16'h0280));
        rd(3, 'h00B, 1'b1);
        rd(7, 'hFFF, 1'b0);
        rd(9, 'h000, 1'b0);
        rd(9, 'h5A3, 1'b0);

        // Restart mid-load, then reset mid-load.
        load(11, 5, 1'b0, 0);
        load(12, 100, 1'b0, 0);
        check("restart_bitmap", wide_t'(o_stage_loaded), wide_t'(16'h0280));
        check("restart_busy", wide_t'(o_load_busy), wide_t'(1'b1));
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
        #2 rst = 1'b1;
        #1;
        check("midload_rst_bitmap", wide_t'(o_stage_loaded), wide_t'(16'h0000));
        check("midload_rst_busy", wide_t'(o_load_busy), wide_t'(1'b0));
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rd(7, 'h000, 1'b1);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL rd_drain: got %0d reads outstanding expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
